servo_ramp_sequencer: RTL and testbench

Sequences the four-channel PWM servo controller by slewing each commanded servo angle toward its target at a bounded rate. Once per servo frame it steps every channel by at most STEP degrees. It then drives the updated angle1..angle4 values and pulses nextangle so the PWM block latches them. It sits between the command/host logic and the PWM servo controller, and is the only driver of that controller's angle and nextangle inputs.

---
 rtl/servo_ramp_sequencer.sv | 123 ++++++++++++
 tb/tb_servo_ramp_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/servo_ramp_sequencer.sv
// Slews four servo target angles toward their commanded values at a bounded rate per frame,
// then strobes nextangle so the downstream PWM controller latches the new angles.
module servo_ramp_sequencer #(
  parameter int unsigned FRAME_CYCLES = 1000000,
  parameter int unsigned STEP         = 4,
  parameter int unsigned MAX_ANGLE    = 180,
  parameter int unsigned HOME         = 90
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_chan,
  input  logic [7:0] cmd_angle,
  output logic [7:0] angle1,
  output logic [7:0] angle2,
  output logic [7:0] angle3,
  output logic [7:0] angle4,
  output logic       nextangle,
  output logic       all_at_target
);

  localparam int unsigned    CntW     = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(FRAME_CYCLES - 1);
  localparam logic [7:0]     MaxAngle = 8'(MAX_ANGLE);
  localparam logic [7:0]     Home     = 8'(HOME);
  localparam logic [8:0]     Step9    = 9'(STEP);

  typedef enum logic [1:0] {StIdle, StUpdate, StStrobe} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      chan_q;
  logic            changed_q;
  logic [7:0]      tgt_q [4];
  logic [7:0]      cur_q [4];

  logic       frame_tick;
  logic [7:0] sel_cur;
  logic [7:0] sel_tgt;
  logic [7:0] cur_new;
  logic [8:0] diff;
  logic [7:0] cmd_clamped;
  logic       at_all;

  always_comb begin
    frame_tick  = (cnt_q == CntMax);
    sel_cur     = cur_q[chan_q];
    sel_tgt     = tgt_q[chan_q];
    diff        = '0;
    cur_new     = sel_cur;
    // 9-bit differences: the step never overshoots the target nor wraps.
    if (sel_cur < sel_tgt) begin
      diff    = {1'b0, sel_tgt} - {1'b0, sel_cur};
      cur_new = sel_cur + 8'((diff < Step9) ? diff : Step9);
    end else begin
      diff    = {1'b0, sel_cur} - {1'b0, sel_tgt};
      cur_new = sel_cur - 8'((diff < Step9) ? diff : Step9);
    end
    cmd_clamped = (cmd_angle > MaxAngle) ? MaxAngle : cmd_angle;
    at_all      = (cur_q[0] == tgt_q[0]) && (cur_q[1] == tgt_q[1]) &&
                  (cur_q[2] == tgt_q[2]) && (cur_q[3] == tgt_q[3]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      chan_q        <= '0;
      changed_q     <= 1'b0;
      cmd_ready     <= 1'b0;
      nextangle     <= 1'b0;
      all_at_target <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        tgt_q[i] <= Home;
        cur_q[i] <= Home;
      end
    end else begin
      cnt_q         <= frame_tick ? '0 : cnt_q + CntW'(1);
      all_at_target <= at_all;
      nextangle     <= 1'b0;
      if (cmd_valid && cmd_ready) tgt_q[cmd_chan] <= cmd_clamped;
      unique case (state_q)
        StIdle: begin
          cmd_ready <= 1'b1;
          if (frame_tick) begin
            state_q   <= StUpdate;
            chan_q    <= '0;
            changed_q <= 1'b0;
            cmd_ready <= 1'b0;
          end
        end
        StUpdate: begin
          cur_q[chan_q] <= cur_new;
          if (cur_new != sel_cur) changed_q <= 1'b1;
          if (chan_q == 2'd3) begin
            // Include a change on the last channel, which changed_q has not seen yet.
            if (changed_q || (cur_new != sel_cur)) begin
              state_q   <= StStrobe;
              nextangle <= 1'b1;
            end else begin
              state_q   <= StIdle;
              cmd_ready <= 1'b1;
            end
          end else begin
            chan_q <= chan_q + 2'd1;
          end
        end
        StStrobe: begin
          state_q   <= StIdle;
          cmd_ready <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign angle1 = cur_q[0];
  assign angle2 = cur_q[1];
  assign angle3 = cur_q[2];
  assign angle4 = cur_q[3];

endmodule

// File: tb/tb_servo_ramp_sequencer.sv
// Randomized and directed bench for servo_ramp_sequencer against a frame-level reference model.
module tb_servo_ramp_sequencer;

  localparam int FC   = 16;
  localparam int STEP = 4;
  localparam int MAXA = 180;
  localparam int HOME = 90;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_chan;
  logic [7:0] cmd_angle;
  logic [7:0] angle1, angle2, angle3, angle4;
  logic       nextangle;
  logic       all_at_target;

  always #5 clk = ~clk;

  servo_ramp_sequencer #(
    .FRAME_CYCLES(FC),
    .STEP        (STEP),
    .MAX_ANGLE   (MAXA),
    .HOME        (HOME)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_chan     (cmd_chan),
    .cmd_angle    (cmd_angle),
    .angle1       (angle1),
    .angle2       (angle2),
    .angle3       (angle3),
    .angle4       (angle4),
    .nextangle    (nextangle),
    .all_at_target(all_at_target)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: edges since reset, phase within the current frame (-1 when idle),
  // targets, and the angles the PWM side should currently see.
  int m_n, m_p;
  int m_tgt [4];
  int m_old [4];
  int m_new [4];
  int m_disp[4];
  bit m_chg, e_ready, e_next, e_aat;

  function automatic int ramp(input int c, input int t);
    if (c < t) return c + (((t - c) < STEP) ? (t - c) : STEP);
    if (c > t) return c - (((c - t) < STEP) ? (c - t) : STEP);
    return c;
  endfunction

  task automatic model_edge();
    bit aat;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_tgt[i]  = HOME;
        m_disp[i] = HOME;
      end
      m_n = 0; m_p = -1; m_chg = 0;
      e_ready = 0; e_next = 0; e_aat = 0;
    end else begin
      aat = 1;
      for (int i = 0; i < 4; i++) if (m_disp[i] != m_tgt[i]) aat = 0;
      if (cmd_valid && e_ready)
        m_tgt[cmd_chan] = (int'(cmd_angle) > MAXA) ? MAXA : int'(cmd_angle);
      m_n++;
      if (m_p >= 0) m_p++;
      if ((m_n % FC) == 0 && m_p < 0) begin
        m_p = 0; m_chg = 0;
        for (int i = 0; i < 4; i++) begin
          m_old[i] = m_disp[i];
          m_new[i] = ramp(m_disp[i], m_tgt[i]);
          if (m_new[i] != m_old[i]) m_chg = 1;
        end
      end
      if (m_p >= 0)
        for (int i = 0; i < 4; i++) m_disp[i] = (m_p >= i + 1) ? m_new[i] : m_old[i];
      e_next  = (m_p == 4) && m_chg;
      e_ready = !(m_p >= 0 && m_p <= 3) && !(m_p == 4 && m_chg);
      e_aat   = aat;
      if (m_p >= 5 || (m_p == 4 && !m_chg)) m_p = -1;
    end
  endtask

  task automatic check_outputs();
    check_val("angle1", int'(angle1), m_disp[0]);
    check_val("angle2", int'(angle2), m_disp[1]);
    check_val("angle3", int'(angle3), m_disp[2]);
    check_val("angle4", int'(angle4), m_disp[3]);
    check_val("nextangle", int'(nextangle), int'(e_next));
    check_val("cmd_ready", int'(cmd_ready), int'(e_ready));
    check_val("all_at_target", int'(all_at_target), int'(e_aat));
  endtask

  task automatic step(input logic r, input logic v, input logic [1:0] c, input logic [7:0] a);
    rst_n = r; cmd_valid = v; cmd_chan = c; cmd_angle = a;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 2'd0, 8'd0);
  endtask

  // Holds the command until the model says it is accepted.
  task automatic send(input logic [1:0] c, input logic [7:0] a);
    bit acc;
    acc = 0;
    for (int k = 0; k < 40 && !acc; k++) begin
      acc = e_ready;
      step(1'b1, 1'b1, c, a);
    end
    check_val("send_accepted", int'(acc), 1);
  endtask

  task automatic wait_phase0();
    for (int k = 0; k < 40 && m_p != 0; k++) idle(1);
    check_val("reach_update", m_p, 0);
  endtask

  task automatic wait_pretick();
    for (int k = 0; k < 40 && !((m_n % FC) == FC - 1 && m_p < 0); k++) idle(1);
    check_val("reach_pretick", m_n % FC, FC - 1);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_chan = 2'd0; cmd_angle = 8'd0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 2'd0, 8'd0);
    idle(5 * FC);
    // Up-ramp, then clamp and down-ramp on two channels at once.
    send(2'd0, 8'd100);
    idle(4 * FC);
    send(2'd1, 8'd200);
    send(2'd2, 8'd0);
    idle(25 * FC);
    // Partial step.
    send(2'd3, 8'd88);
    idle(2 * FC);
    // Command held across an update window.
    wait_phase0();
    send(2'd1, 8'd90);
    idle(3 * FC);
    // Command landing on the frame tick edge.
    wait_pretick();
    step(1'b1, 1'b1, 2'd0, 8'd150);
    idle(2 * FC);
    // Reset in the middle of an update sequence.
    wait_phase0();
    idle(1);
    step(1'b0, 1'b0, 2'd0, 8'd0);
    step(1'b0, 1'b0, 2'd0, 8'd0);
    idle(3 * FC);
    // Randomized traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      step(logic'($urandom_range(0, 499) != 0), logic'($urandom_range(0, 3) == 0),
           2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
